// File: rtl/mips_pipe_pkg.sv
// mips_pipe_pkg: shared pipeline control types and constants for the 4-stage MIPS core.
package mips_pipe_pkg;
  typedef enum logic {ST_RUN = 1'b0, ST_MUL_WAIT = 1'b1} state_e;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
  localparam int STG_IF = 0;
  localparam int STG_ID = 1;
  localparam int STG_EX = 2;
  localparam int STG_WB = 3;
endpackage

// File: rtl/sat_counter.sv
// sat_counter: width-parameterised increment-with-saturate counter.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt_o <= '0;
    else if (inc_i && !(&cnt_o)) cnt_o <= cnt_o + 1'b1;
endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: per-cycle enable/flush control for the IF/ID/EX/WB pipe,
// including the multi-cycle multiply stall and a stall-cycle statistic.
module hazard_ctrl
  import mips_pipe_pkg::*;
#(
  parameter int MUL_LATENCY = 4,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             mem_busy_i,
  input  logic             branch_taken_i,
  input  logic             load_use_i,
  input  logic             mul_start_i,
  output logic             pc_en_o,
  output logic             ifid_en_o,
  output logic             ifid_flush_o,
  output logic             idex_en_o,
  output logic             idex_flush_o,
  output logic             exwb_en_o,
  output logic             exwb_flush_o,
  output logic             busy_o,
  output logic [CNT_W-1:0] stall_cycles_o
);
  state_e     r_state, w_state_nxt;
  logic [7:0] r_mul_cnt, w_mul_cnt_nxt;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_state   <= ST_RUN;
      r_mul_cnt <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_mul_cnt <= w_mul_cnt_nxt;
    end

  // Freeze outranks everything and holds the multiply countdown.
  always_comb begin
    w_state_nxt   = r_state;
    w_mul_cnt_nxt = r_mul_cnt;
    pc_en_o       = 1'b1;
    ifid_en_o     = 1'b1;
    ifid_flush_o  = 1'b0;
    idex_en_o     = 1'b1;
    idex_flush_o  = 1'b0;
    exwb_en_o     = 1'b1;
    exwb_flush_o  = 1'b0;
    if (mem_busy_i) begin
      pc_en_o   = 1'b0;
      ifid_en_o = 1'b0;
      idex_en_o = 1'b0;
      exwb_en_o = 1'b0;
    end else if (r_state == ST_MUL_WAIT) begin
      pc_en_o       = 1'b0;
      ifid_en_o     = 1'b0;
      idex_en_o     = 1'b0;
      exwb_flush_o  = 1'b1;
      w_state_nxt   = (r_mul_cnt == 8'd0) ? ST_RUN : ST_MUL_WAIT;
      w_mul_cnt_nxt = (r_mul_cnt == 8'd0) ? r_mul_cnt : r_mul_cnt - 8'd1;
    end else if (branch_taken_i) begin
      ifid_flush_o = 1'b1;
      idex_flush_o = 1'b1;
    end else if (load_use_i) begin
      pc_en_o      = 1'b0;
      ifid_en_o    = 1'b0;
      idex_flush_o = 1'b1;
    end else if (mul_start_i) begin
      w_state_nxt   = ST_MUL_WAIT;
      w_mul_cnt_nxt = 8'(MUL_LATENCY - 1);
    end
  end

  assign busy_o = (r_state == ST_MUL_WAIT);

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc_i (!pc_en_o),
    .cnt_o (stall_cycles_o)
  );
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed self-checking bench for hazard_ctrl (MUL_LATENCY=4, CNT_W=4).
module tb_hazard_ctrl;
  localparam int CW = 4;
  // Output vector order: pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exwb_en, exwb_flush, busy
  localparam logic [7:0] V_NORMAL = 8'b1101_0100;
  localparam logic [7:0] V_LDUSE  = 8'b0001_1100;
  localparam logic [7:0] V_BRANCH = 8'b1111_1100;
  localparam logic [7:0] V_MULW   = 8'b0000_0111;
  localparam logic [7:0] V_FRZW   = 8'b0000_0001;

  logic clk = 1'b0, rst_n = 1'b0;
  logic mem_busy = 1'b0, branch = 1'b0, load_use = 1'b0, mul_start = 1'b0;
  logic pc_en, ifid_en, ifid_fl, idex_en, idex_fl, exwb_en, exwb_fl, busy;
  logic [CW-1:0] stall;
  logic [7:0] w_o;
  int nchk = 0, nerr = 0;

  assign w_o = {pc_en, ifid_en, ifid_fl, idex_en, idex_fl, exwb_en, exwb_fl, busy};

  always #5 clk = ~clk;

  hazard_ctrl #(.MUL_LATENCY(4), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .mem_busy_i(mem_busy), .branch_taken_i(branch),
    .load_use_i(load_use), .mul_start_i(mul_start), .pc_en_o(pc_en),
    .ifid_en_o(ifid_en), .ifid_flush_o(ifid_fl), .idex_en_o(idex_en),
    .idex_flush_o(idex_fl), .exwb_en_o(exwb_en), .exwb_flush_o(exwb_fl),
    .busy_o(busy), .stall_cycles_o(stall)
  );

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    {mem_busy, branch, load_use, mul_start} = '0;
    rst_n = 1'b0;
    #3;
    @(negedge clk) rst_n = 1'b1;
    next_cycle();
  endtask

  task automatic test_reset();
    apply_reset();
    @(negedge clk);
    nchk++; if (w_o !== V_NORMAL) begin nerr++; $display("FAIL reset_outs got %b want %b", w_o, V_NORMAL); end
    nchk++; if (stall !== 4'd0) begin nerr++; $display("FAIL reset_stall got %0d want 0", stall); end
    next_cycle();
    load_use = 1'b1;
    next_cycle();
    load_use = 1'b0;
    @(negedge clk);
    nchk++; if (stall !== 4'd1) begin nerr++; $display("FAIL pre_async_stall got %0d want 1", stall); end
    #2 rst_n = 1'b0;
    #1;
    nchk++; if (stall !== 4'd0) begin nerr++; $display("FAIL async_reset_stall got %0d want 0", stall); end
    nchk++; if (w_o !== V_NORMAL) begin nerr++; $display("FAIL async_reset_outs got %b want %b", w_o, V_NORMAL); end
    @(negedge clk) rst_n = 1'b1;
    next_cycle();
  endtask

  task automatic test_load_use();
    apply_reset();
    load_use = 1'b1;
    @(negedge clk);
    nchk++; if (w_o !== V_LDUSE) begin nerr++; $display("FAIL load_use_outs got %b want %b", w_o, V_LDUSE); end
    next_cycle();
    load_use = 1'b0;
    @(negedge clk);
    nchk++; if (w_o !== V_NORMAL) begin nerr++; $display("FAIL load_use_after got %b want %b", w_o, V_NORMAL); end
    nchk++; if (stall !== 4'd1) begin nerr++; $display("FAIL load_use_stall got %0d want 1", stall); end
    next_cycle();
  endtask

  task automatic test_branch_combo();
    apply_reset();
    {branch, load_use, mul_start} = 3'b111;
    @(negedge clk);
    nchk++; if (w_o !== V_BRANCH) begin nerr++; $display("FAIL branch_outs got %b want %b", w_o, V_BRANCH); end
    next_cycle();
    {branch, load_use, mul_start} = 3'b000;
    @(negedge clk);
    nchk++; if (w_o !== V_NORMAL) begin nerr++; $display("FAIL branch_no_mul got %b want %b", w_o, V_NORMAL); end
    nchk++; if (stall !== 4'd0) begin nerr++; $display("FAIL branch_stall got %0d want 0", stall); end
    next_cycle();
  endtask

  task automatic test_multiply();
    apply_reset();
    mul_start = 1'b1;
    @(negedge clk);
    nchk++; if (w_o !== V_NORMAL) begin nerr++; $display("FAIL mul_accept got %b want %b", w_o, V_NORMAL); end
    next_cycle();
    mul_start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      nchk++; if (w_o !== V_MULW) begin nerr++; $display("FAIL mul_wait%0d got %b want %b", i, w_o, V_MULW); end
      next_cycle();
    end
    @(negedge clk);
    nchk++; if (w_o !== V_NORMAL) begin nerr++; $display("FAIL mul_done got %b want %b", w_o, V_NORMAL); end
    nchk++; if (stall !== 4'd4) begin nerr++; $display("FAIL mul_stall got %0d want 4", stall); end
    next_cycle();
  endtask

  task automatic test_freeze();
    logic [7:0] exp;
    int nbusy;
    nbusy = 0;
    apply_reset();
    mul_start = 1'b1;
    next_cycle();
    mul_start = 1'b0;
    for (int i = 0; i < 7; i++) begin
      mem_busy = (i >= 2 && i < 5);
      exp = mem_busy ? V_FRZW : V_MULW;
      @(negedge clk);
      nchk++; if (w_o !== exp) begin nerr++; $display("FAIL freeze_cyc%0d got %b want %b", i, w_o, exp); end
      if (busy) nbusy++;
      next_cycle();
    end
    mem_busy = 1'b0;
    @(negedge clk);
    nchk++; if (w_o !== V_NORMAL) begin nerr++; $display("FAIL freeze_done got %b want %b", w_o, V_NORMAL); end
    nchk++; if (nbusy !== 7) begin nerr++; $display("FAIL freeze_busy_cycles got %0d want 7", nbusy); end
    nchk++; if (stall !== 4'd7) begin nerr++; $display("FAIL freeze_stall got %0d want 7", stall); end
    next_cycle();
  endtask

  task automatic test_saturation();
    logic [CW-1:0] exp;
    apply_reset();
    load_use = 1'b1;
    for (int i = 0; i < 20; i++) begin
      exp = (i > 15) ? 4'd15 : CW'(i);
      @(negedge clk);
      nchk++; if (stall !== exp) begin nerr++; $display("FAIL sat_cyc%0d got %0d want %0d", i, stall, exp); end
      next_cycle();
    end
    load_use = 1'b0;
    @(negedge clk);
    nchk++; if (stall !== 4'd15) begin nerr++; $display("FAIL sat_hold got %0d want 15", stall); end
    next_cycle();
  endtask

  task automatic test_reset_mid_wait();
    apply_reset();
    mul_start = 1'b1;
    next_cycle();
    mul_start = 1'b0;
    next_cycle();
    @(negedge clk);
    nchk++; if (w_o !== V_MULW || stall !== 4'd1) begin nerr++; $display("FAIL mid_wait_pre got %b/%0d want %b/1", w_o, stall, V_MULW); end
    #2 rst_n = 1'b0;
    #1;
    nchk++; if (w_o !== V_NORMAL) begin nerr++; $display("FAIL mid_wait_reset_outs got %b want %b", w_o, V_NORMAL); end
    nchk++; if (stall !== 4'd0) begin nerr++; $display("FAIL mid_wait_reset_stall got %0d want 0", stall); end
    @(negedge clk) rst_n = 1'b1;
    next_cycle();
    @(negedge clk);
    nchk++; if (w_o !== V_NORMAL) begin nerr++; $display("FAIL mid_wait_after got %b want %b", w_o, V_NORMAL); end
    next_cycle();
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_branch_combo();
    test_multiply();
    test_freeze();
    test_saturation();
    test_reset_mid_wait();
    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end
endmodule
